// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
//  Module   : seq_detector_param
//  Purpose  : Parametrised Mealy serial pattern detector. It has a
//             runtime-loadable pattern, an overlap or non-overlap mode, a
//             sample enable, a registered copy of the match flag and a
//             saturating match counter.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_detector_param #(
   parameter int                 PAT_LEN = 4,
   parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
   parameter int                 OVERLAP = 1,
   parameter int                 CNT_W   = 8
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               En,
   input  logic               In,
   input  logic               Pat_load,
   input  logic [PAT_LEN-1:0] Pat_in,
   input  logic               Cnt_clr,
   output logic               Out,
   output logic               Out_q,
   output logic [CNT_W-1:0]   Match_cnt,
   output logic               Cnt_sat
);

   localparam int                c_fill_w   = $clog2(PAT_LEN);
   localparam logic [c_fill_w-1:0] c_fill_max = c_fill_w'(PAT_LEN - 1);
   localparam logic [CNT_W-1:0]  c_cnt_max  = {CNT_W{1'b1}};

   logic [PAT_LEN-2:0]  r_hist;
   logic [c_fill_w-1:0] r_fill;
   logic [PAT_LEN-1:0]  r_pat;
   logic                r_out_q;
   logic [CNT_W-1:0]    r_cnt;

   logic [PAT_LEN-1:0]  w_shift;
   logic                w_match;

   // The oldest history bit lines up with the pattern MSB and the live input with the LSB.
   // Gating with Reset keeps Out low for the whole time reset is asserted.
   always_comb begin
      w_shift = {r_hist, In};
      w_match = Reset & En & ~Pat_load & (r_fill == c_fill_max) & (w_shift == r_pat);
   end

   // History, fill level and pattern register. A load wins over sampling and discards In.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_hist <= '0;
         r_fill <= '0;
         r_pat  <= PATTERN;
      end else if (Pat_load) begin
         r_pat  <= Pat_in;
         r_hist <= '0;
         r_fill <= '0;
      end else if (En) begin
         if (w_match && (OVERLAP == 0)) begin
            // Non-overlap mode: a fresh PAT_LEN bits are needed before the next match.
            r_hist <= '0;
            r_fill <= '0;
         end else begin
            r_hist <= w_shift[PAT_LEN-2:0];
            if (r_fill != c_fill_max) begin
               r_fill <= r_fill + 1'b1;
            end
         end
      end
   end

   // Registered copy of the match flag, one cycle behind Out.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_out_q <= 1'b0;
      end else begin
         r_out_q <= w_match;
      end
   end

   // Saturating match counter. A clear wins over a simultaneous match.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_cnt <= '0;
      end else if (Cnt_clr) begin
         r_cnt <= '0;
      end else if (w_match && (r_cnt != c_cnt_max)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign Out       = w_match;
   assign Out_q     = r_out_q;
   assign Match_cnt = r_cnt;
   assign Cnt_sat   = &r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_detector_param
//  Purpose  : Self-checking bench for seq_detector_param. It drives four
//             differently parametrised instances from shared stimulus and
//             checks one selected instance per vector table.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_detector_param;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       din;
   logic       load;
   logic [3:0] pin;
   logic       clr;

   logic       out_w  [4];
   logic       outq_w [4];
   logic [7:0] cnt_w  [4];
   logic       sat_w  [4];
   logic [1:0] cnt3;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic       en;
      logic       din;
      logic       load;
      logic [3:0] pin;
      logic       clr;
      logic       eo;
      logic [7:0] ecnt;
      logic       esat;
   } vec_t;

   typedef struct {
      int         dut;
      logic       eo;
      logic [7:0] ecnt;
      logic       esat;
   } sb_t;

   vec_t tbl[$];
   sb_t  sbq[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // 0: defaults (1011, overlap)  1: 1111 non-overlap  2: 1111 overlap  3: 1011 with 2-bit counter
   seq_detector_param u_dut0 (
      .Clk(clk), .Reset(rst_n), .En(en), .In(din), .Pat_load(load), .Pat_in(pin),
      .Cnt_clr(clr), .Out(out_w[0]), .Out_q(outq_w[0]), .Match_cnt(cnt_w[0]), .Cnt_sat(sat_w[0]));

   seq_detector_param #(.PATTERN(4'b1111), .OVERLAP(0)) u_dut1 (
      .Clk(clk), .Reset(rst_n), .En(en), .In(din), .Pat_load(load), .Pat_in(pin),
      .Cnt_clr(clr), .Out(out_w[1]), .Out_q(outq_w[1]), .Match_cnt(cnt_w[1]), .Cnt_sat(sat_w[1]));

   seq_detector_param #(.PATTERN(4'b1111), .OVERLAP(1)) u_dut2 (
      .Clk(clk), .Reset(rst_n), .En(en), .In(din), .Pat_load(load), .Pat_in(pin),
      .Cnt_clr(clr), .Out(out_w[2]), .Out_q(outq_w[2]), .Match_cnt(cnt_w[2]), .Cnt_sat(sat_w[2]));

   seq_detector_param #(.CNT_W(2)) u_dut3 (
      .Clk(clk), .Reset(rst_n), .En(en), .In(din), .Pat_load(load), .Pat_in(pin),
      .Cnt_clr(clr), .Out(out_w[3]), .Out_q(outq_w[3]), .Match_cnt(cnt3), .Cnt_sat(sat_w[3]));

   assign cnt_w[3] = {6'b0, cnt3};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic e, input logic d, input logic l, input logic [3:0] p,
                      input logic c, input logic eo, input logic [7:0] ecnt, input logic esat);
      vec_t v;
      v.en = e; v.din = d; v.load = l; v.pin = p; v.clr = c;
      v.eo = eo; v.ecnt = ecnt; v.esat = esat;
      tbl.push_back(v);
   endtask

   // Shorthand for a plain enabled data bit
   task automatic bit_(input logic d, input logic eo, input logic [7:0] ecnt, input logic esat);
      add(1'b1, d, 1'b0, 4'b0000, 1'b0, eo, ecnt, esat);
   endtask

   task automatic do_reset();
      @(negedge clk);
      en = 1'b0; din = 1'b0; load = 1'b0; pin = 4'b0000; clr = 1'b0;
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   // Apply every queued vector to the shared inputs and check instance k.
   // Out is checked before the edge. The expected registered results go into the
   // scoreboard and are popped once the edge has produced them.
   task automatic run_tbl(input int k, input string tag);
      sb_t s;
      sb_t r;
      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         en = tbl[i].en; din = tbl[i].din; load = tbl[i].load;
         pin = tbl[i].pin; clr = tbl[i].clr;
         #1;
         chk($sformatf("%s[%0d].Out", tag, i), {31'b0, out_w[k]}, {31'b0, tbl[i].eo});
         s.dut = k; s.eo = tbl[i].eo; s.ecnt = tbl[i].ecnt; s.esat = tbl[i].esat;
         sbq.push_back(s);
         @(posedge clk);
         #1;
         r = sbq.pop_front();
         chk($sformatf("%s[%0d].Out_q", tag, i), {31'b0, outq_w[r.dut]}, {31'b0, r.eo});
         chk($sformatf("%s[%0d].Match_cnt", tag, i), {24'b0, cnt_w[r.dut]}, {24'b0, r.ecnt});
         chk($sformatf("%s[%0d].Cnt_sat", tag, i), {31'b0, sat_w[r.dut]}, {31'b0, r.esat});
      end
      tbl.delete();
   endtask

   initial begin
      rst_n = 1'b0;
      en = 1'b0; din = 1'b0; load = 1'b0; pin = 4'b0000; clr = 1'b0;
      #12;
      // Check the reset state of every instance while reset is held.
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("rst%0d.Out", k), {31'b0, out_w[k]}, 32'd0);
         chk($sformatf("rst%0d.Out_q", k), {31'b0, outq_w[k]}, 32'd0);
         chk($sformatf("rst%0d.Match_cnt", k), {24'b0, cnt_w[k]}, 32'd0);
         chk($sformatf("rst%0d.Cnt_sat", k), {31'b0, sat_w[k]}, 32'd0);
      end
      rst_n = 1'b1;

      // Overlapping default pattern: matches on bits 4 and 7.
      bit_(1,0,0,0); bit_(0,0,0,0); bit_(1,0,0,0); bit_(1,1,1,0);
      bit_(0,0,1,0); bit_(1,0,1,0); bit_(1,1,2,0);
      run_tbl(0, "ovl");

      // All-ones pattern in non-overlap mode: a single match within seven 1s.
      do_reset();
      bit_(1,0,0,0); bit_(1,0,0,0); bit_(1,0,0,0); bit_(1,1,1,0);
      bit_(1,0,1,0); bit_(1,0,1,0); bit_(1,0,1,0);
      run_tbl(1, "novl");

      // All-ones pattern in overlap mode: matches on bits 4..7.
      do_reset();
      bit_(1,0,0,0); bit_(1,0,0,0); bit_(1,0,0,0); bit_(1,1,1,0);
      bit_(1,1,2,0); bit_(1,1,3,0); bit_(1,1,4,0);
      run_tbl(2, "ones");

      // Enable gaps: bits with En=0 are ignored and never produce Out.
      do_reset();
      bit_(1,0,0,0); bit_(0,0,0,0);
      add(0,1,0,4'b0000,0, 0,0,0);
      add(0,0,0,4'b0000,0, 0,0,0);
      add(0,1,0,4'b0000,0, 0,0,0);
      bit_(1,0,0,0); bit_(1,1,1,0);
      run_tbl(0, "en");

      // Pattern load: In=1 in the load cycle would have completed 1011, so Out stays low.
      do_reset();
      bit_(1,0,0,0); bit_(0,0,0,0); bit_(1,0,0,0);
      add(1,1,1,4'b0110,0, 0,0,0);
      bit_(0,0,0,0); bit_(1,0,0,0); bit_(1,0,0,0); bit_(0,1,1,0);
      bit_(1,0,1,0); bit_(0,0,1,0); bit_(1,0,1,0); bit_(1,0,1,0);
      run_tbl(0, "load");

      // 2-bit counter saturates at 3. The clear wins over a coincident match.
      do_reset();
      bit_(1,0,0,0); bit_(0,0,0,0); bit_(1,0,0,0); bit_(1,1,1,0);
      bit_(0,0,1,0); bit_(1,0,1,0); bit_(1,1,2,0);
      bit_(0,0,2,0); bit_(1,0,2,0); bit_(1,1,3,1);
      bit_(0,0,3,1); bit_(1,0,3,1); bit_(1,1,3,1);
      bit_(0,0,3,1); bit_(1,0,3,1); bit_(1,1,3,1);
      bit_(0,0,3,1); bit_(1,0,3,1);
      add(1,1,0,4'b0000,1, 1,0,0);
      add(1,0,0,4'b0000,1, 0,0,0);
      run_tbl(3, "sat");

      // Asynchronous reset mid-stream. First get a match and a live pending match.
      do_reset();
      bit_(1,0,0,0); bit_(0,0,0,0); bit_(1,0,0,0); bit_(1,1,1,0);
      bit_(0,0,1,0); bit_(1,0,1,0);
      run_tbl(0, "pre");
      @(negedge clk);
      en = 1'b1; din = 1'b1;
      #1;
      chk("arst.Out_before", {31'b0, out_w[0]}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("arst.Out", {31'b0, out_w[0]}, 32'd0);
      chk("arst.Out_q", {31'b0, outq_w[0]}, 32'd0);
      chk("arst.Match_cnt", {24'b0, cnt_w[0]}, 32'd0);
      chk("arst.Cnt_sat", {31'b0, sat_w[0]}, 32'd0);
      #1;
      rst_n = 1'b1;
      // History was lost: the pending 1 no match, a full 1,0,1,1 then matches.
      bit_(1,0,0,0);
      bit_(1,0,0,0); bit_(0,0,0,0); bit_(1,0,0,0); bit_(1,1,1,0);
      run_tbl(0, "post");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
